// File: rtl/pcie_egress_rr_pkg.sv
// pcie_egress_rr_pkg
//   Shared definitions for the PCIe egress round-robin stage: FSM state
//   encoding and output-buffer depth.
package pcie_egress_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/egress_obuf.sv
// egress_obuf
//   Two-entry FIFO output buffer for the egress stage. Holds data word plus
//   source tag, presents the head entry as a valid/ready stream.
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   wr_en_i               write a captured word (space guaranteed by caller)
//   wr_data_i, wr_dst_i   word and source tag to write
//   rd_ready_i            sink accepts the head entry
//   valid_o               buffer non-empty
//   data_o, dst_o         head entry
//   occ_o                 entries held (0..2)
module egress_obuf
  import pcie_egress_rr_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_dst_i,
  input  logic         rd_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         dst_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] data_q [OBUF_DEPTH];
  logic         dst_q  [OBUF_DEPTH];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   occ_q, occ_d;
  logic         rd;

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = data_q[rd_ptr_q];
  assign dst_o   = dst_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign rd      = valid_o && rd_ready_i;

  always_comb begin
    occ_d = occ_q;
    case ({wr_en_i, rd})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        data_q[i] <= '0;
        dst_q[i]  <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr_en_i) begin
        data_q[wr_ptr_q] <= wr_data_i;
        dst_q[wr_ptr_q]  <= wr_dst_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/pcie_egress_rr.sv
// pcie_egress_rr
//   Egress stage after the transaction layer. Drains FIFOs D0/D1 with
//   round-robin arbitration into one valid/ready stream tagged with source.
//   Pops are credit-limited so the 1-cycle FIFO read latency never
//   overruns the 2-entry output buffer under backpressure.
// Ports
//   clk, reset (async, active low), enable
//   data_out0/1, D0/D1_can_pop   FIFO read data and non-empty flags
//   pop_D0/1                     FIFO read strobes
//   ready_in, valid_out, data_out, dst_out   output stream
//   idle                         FSM in IDLE
//   cnt_D0/1                     per-source delivered-word counters
// Configuration
//   PCIE_EGRESS_STATS_EN: build the delivered-word counters; otherwise
//   cnt_D0/cnt_D1 are constant 0.
module pcie_egress_rr
  import pcie_egress_rr_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BITNUMBER-1:0] data_out0,
  input  logic [BITNUMBER-1:0] data_out1,
  input  logic                 D0_can_pop,
  input  logic                 D1_can_pop,
  output logic                 pop_D0,
  output logic                 pop_D1,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 dst_out,
  output logic                 idle,
  output logic [CNT_W-1:0]     cnt_D0,
  output logic [CNT_W-1:0]     cnt_D1
);

  state_e     state_q;
  logic       idle_q;
  logic       inflight_q, inflight_d;
  logic       src_q, src_d;         // source of the in-flight word
  logic       rr_last_q, rr_last_d; // side granted by the most recent pop
  logic [1:0] occ;
  logic       xfer, credit_ok, pop, grant;
  logic [2:0] held;

  assign xfer = valid_out && ready_in;

  // Words already committed (buffered + in flight) minus the one leaving
  // this cycle must leave room for one more.
  assign held      = {1'b0, occ} + {2'b0, inflight_q};
  assign credit_ok = held < (3'd2 + {2'b0, xfer});

  always_comb begin
    pop   = 1'b0;
    grant = 1'b0;
    if (state_q == RUN && credit_ok) begin
      if (D0_can_pop && D1_can_pop) begin
        pop   = 1'b1;
        grant = ~rr_last_q;
      end else if (D0_can_pop) begin
        pop   = 1'b1;
        grant = 1'b0;
      end else if (D1_can_pop) begin
        pop   = 1'b1;
        grant = 1'b1;
      end
    end
  end

  assign pop_D0     = pop && !grant;
  assign pop_D1     = pop && grant;
  assign inflight_d = pop;
  assign src_d      = pop ? grant : src_q;
  assign rr_last_d  = pop ? grant : rr_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      src_q      <= 1'b0;
      rr_last_q  <= 1'b1;  // D0 wins the first contested grant
    end else begin
      inflight_q <= inflight_d;
      src_q      <= src_d;
      rr_last_q  <= rr_last_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          state_q <= RUN;
          idle_q  <= 1'b0;
        end
        RUN: if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state_q <= RUN;
          end else if (!inflight_q && occ == 2'd0) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign idle = idle_q;

  egress_obuf #(.W(BITNUMBER)) u_obuf (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_en_i    (inflight_q),
    .wr_data_i  (src_q ? data_out1 : data_out0),
    .wr_dst_i   (src_q),
    .rd_ready_i (ready_in),
    .valid_o    (valid_out),
    .data_o     (data_out),
    .dst_o      (dst_out),
    .occ_o      (occ)
  );

`ifdef PCIE_EGRESS_STATS_EN
  logic [CNT_W-1:0] cnt_d0_q, cnt_d1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else if (xfer) begin
      if (dst_out) cnt_d1_q <= cnt_d1_q + 1'b1;
      else         cnt_d0_q <= cnt_d0_q + 1'b1;
    end
  end

  assign cnt_D0 = cnt_d0_q;
  assign cnt_D1 = cnt_d1_q;
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_pcie_egress_rr.sv
// tb_pcie_egress_rr
//   Self-checking bench: FIFO queues feed the DUT, a transaction-level model
//   predicts pops, output words, latency and idle from the block's rules.
module tb_pcie_egress_rr;

  localparam int BN = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [BN-1:0] data_out0, data_out1;
  logic          D0_can_pop, D1_can_pop;
  logic          pop_D0, pop_D1;
  logic          ready_in;
  logic          valid_out;
  logic [BN-1:0] data_out;
  logic          dst_out;
  logic          idle;
  logic [CW-1:0] cnt_D0, cnt_D1;

  pcie_egress_rr #(.BITNUMBER(BN), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .D0_can_pop (D0_can_pop),
    .D1_can_pop (D1_can_pop),
    .pop_D0     (pop_D0),
    .pop_D1     (pop_D1),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .dst_out    (dst_out),
    .idle       (idle),
    .cnt_D0     (cnt_D0),
    .cnt_D1     (cnt_D1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BN-1:0] d;
    logic          s;
    int            vis;  // first cycle the word may appear on valid_out
  } ent_t;

  ent_t          exp_q[$];
  logic [BN-1:0] q0[$], q1[$];
  int total = 0, bad = 0;
  int cyc = 0, npops = 0, cnt0 = 0, cnt1 = 0;
  bit run_m = 1'b0, idle_m = 1'b1, last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic tick();
    bit xf, vexp, want, side, any;
    int sz;
    ent_t e;
    logic [BN-1:0] w;
    w = '0;
    D0_can_pop = (q0.size() != 0);
    D1_can_pop = (q1.size() != 0);
    #1;
    sz   = exp_q.size();
    vexp = (sz != 0) && (exp_q[0].vis <= cyc);
    xf   = vexp && ready_in;
    chk("valid_out", 32'(valid_out), 32'(vexp));
    if (vexp) begin
      chk("data_out", 32'(data_out), 32'(exp_q[0].d));
      chk("dst_out", 32'(dst_out), 32'(exp_q[0].s));
    end
    any  = D0_can_pop || D1_can_pop;
    want = run_m && any && ((sz - int'(xf)) < 2);
    side = (D0_can_pop && D1_can_pop) ? ~last : !D0_can_pop;
    chk("pop_D0", 32'(pop_D0), 32'(want && !side));
    chk("pop_D1", 32'(pop_D1), 32'(want && side));
    chk("idle", 32'(idle), 32'(idle_m));
    if (xf) begin
      if (exp_q[0].s) cnt1++; else cnt0++;
      void'(exp_q.pop_front());
    end
    if (want) begin
      w = side ? q1.pop_front() : q0.pop_front();
      e.d = w; e.s = side; e.vis = cyc + 2;
      exp_q.push_back(e);
      last = side;
      npops++;
    end
    if (enable) begin
      run_m = 1'b1; idle_m = 1'b0;
    end else if (run_m) begin
      run_m = 1'b0;
    end else if (!idle_m && sz == 0) begin
      idle_m = 1'b1;
    end
    @(posedge clk); #1;
    if (want) begin
      if (side) data_out1 = w; else data_out0 = w;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain_all(input int bound);
    int n;
    n = 0;
    ready_in = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_in_bound", 32'(n < bound), 32'd1);
  endtask

  task automatic chk_stats();
`ifdef PCIE_EGRESS_STATS_EN
    chk("cnt_D0", 32'(cnt_D0), 32'(cnt0 % (1 << CW)));
    chk("cnt_D1", 32'(cnt_D1), 32'(cnt1 % (1 << CW)));
`else
    chk("cnt_D0", 32'(cnt_D0), 32'd0);
    chk("cnt_D1", 32'(cnt_D1), 32'd0);
`endif
  endtask

  initial begin
    int p, n;
    reset = 1'b0; enable = 1'b0; ready_in = 1'b0;
    data_out0 = '0; data_out1 = '0;
    D0_can_pop = 1'b0; D1_can_pop = 1'b0;

    // 1: reset values, then no pops while disabled
    @(negedge clk);
    repeat (3) tick();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_dst_out", 32'(dst_out), 32'd0);
    chk_stats();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(BN'($urandom_range(0, 63)));
      q1.push_back(BN'($urandom_range(0, 63)));
    end
    p = npops;
    repeat (4) tick();
    chk("no_pop_disabled", 32'(npops - p), 32'd0);

    // 2: alternation with both sources busy
    for (int i = 0; i < 4; i++) begin
      q0.push_back(BN'($urandom_range(0, 63)));
      q1.push_back(BN'($urandom_range(0, 63)));
    end
    enable = 1'b1; ready_in = 1'b1;
    drain_all(60);

    // 3: backpressure holds pops at two words
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) q0.push_back(BN'(i + 8));
    p = npops;
    repeat (8) tick();
    chk("bp_pops", 32'(npops - p), 32'd2);
    drain_all(40);

    // 4: single source A,B,C
    q0.push_back(6'h0A); q0.push_back(6'h0B); q0.push_back(6'h0C);
    drain_all(30);

    // 5: drop enable right after a pop
    q0.push_back(6'h2D);
    p = npops; n = 0;
    while (npops == p && n < 20) begin
      tick();
      n++;
    end
    chk("pop_seen", 32'(npops - p), 32'd1);
    enable = 1'b0;
    repeat (8) tick();
    chk("drain_idle", 32'(idle), 32'd1);
    chk("drain_no_extra_pop", 32'(npops - p), 32'd1);

    // random traffic, enable and backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(BN'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(BN'($urandom_range(0, 63)));
      ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    enable = 1'b1;
    drain_all(100);
    chk_stats();

    // 6: 260 words from D0 wraps an 8-bit counter
    for (int i = 0; i < 260; i++) q0.push_back(BN'($urandom_range(0, 63)));
    cnt0 = 0; cnt1 = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_m = 1'b0; idle_m = 1'b1; last = 1'b1;
    exp_q.delete();
    drain_all(1200);
    chk_stats();
    enable = 1'b0;
    repeat (5) tick();
    chk("final_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
